phase_scheduler: RTL

PHASE_SCHEDULER -- requirements
Module: phase_scheduler

---
 rtl/gcm_phase_pkg.sv | 43 ++++
 rtl/phase_tag_fifo.sv | 75 +++++++
 rtl/phase_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/gcm_phase_pkg.sv
// gcm_phase_pkg
// Shared definitions for the GCM phase scheduler slice.
//   - TEXT_W / IV_W / CTR_W : widths of a text word, packet IV and block counter
//   - PH_*                  : one-hot phase codes reported on o_state
//   - state_t               : scheduler FSM states
//   - tag_t                 : one entry of the tag FIFO {text, phase, last}
//   - ctrPair()             : builds the {iv,c},{iv,c+1} counter-block pair
package gcm_phase_pkg;

    localparam int TEXT_W = 289;
    localparam int IV_W   = 96;
    localparam int CTR_W  = 32;
    localparam int PH_W   = 4;
    localparam int TAG_W  = TEXT_W + PH_W + 1;
    localparam int BLK_W  = 2 * (IV_W + CTR_W);

    localparam logic [PH_W-1:0] PH_NONE   = 4'd0;
    localparam logic [PH_W-1:0] PH_FIRST  = 4'd1;
    localparam logic [PH_W-1:0] PH_SECOND = 4'd2;
    localparam logic [PH_W-1:0] PH_INNER  = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SECOND,
        ST_INNER,
        ST_DRAIN,
        ST_GAPWAIT
    } state_t;

    typedef struct packed {
        logic [TEXT_W-1:0] text;
        logic [PH_W-1:0]   phase;
        logic              last;
    } tag_t;

    // Cipher 0 gets counter c in the upper half, cipher 1 gets c+1 in the
    // lower half; the add wraps naturally at 2^32.
    function automatic logic [BLK_W-1:0] ctrPair(input logic [IV_W-1:0]  iv,
                                                 input logic [CTR_W-1:0] c);
        return {iv, c, iv, c + CTR_W'(1)};
    endfunction

endpackage

// File: rtl/phase_tag_fifo.sv
// phase_tag_fifo
// Synchronous FIFO holding the tag of every word whose keystream is still
// outstanding. The head entry is visible combinationally on headData_o.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write pushData_i (ignored when full)
//   pushData_i   : entry to store
//   pop_i        : drop the head entry (ignored when empty)
//   headData_o   : oldest entry (undefined contents when empty)
//   empty_o      : no entries stored
//   full_o       : DEPTH entries stored
//   count_o      : number of entries stored
module phase_tag_fifo #(
    parameter int WIDTH = 294,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         pushData_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         headData_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPush;
    logic             doPop;

    assign doPush     = push_i && !full_o;
    assign doPop      = pop_i && !empty_o;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == DEPTH_C);
    assign count_o    = count_q;
    assign headData_o = mem_q[rdPtr_q];

    // Storage array carries no reset; stale contents are never observed
    // because the occupancy count gates every read.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    // Pointers wrap on their own since DEPTH is a power of two; the count
    // is held when a push and a pop land in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            if (doPush && !doPop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (doPop && !doPush) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/phase_scheduler.sv
// phase_scheduler
// Accepts packet text words, issues one AES-CTR counter-block pair per word,
// tags each word with its position in the packet (FIRST / SECOND / INNER)
// and replays the tags in order as keystream pairs come back.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   s_valid/s_ready          : input word handshake
//   s_data/s_sop/s_eop/s_iv  : text word, packet delimiters, packet IV
//   ctr_valid/ctr_ready      : counter-pair handshake toward the AES core
//   ctr_block                : {iv,c} in [255:128], {iv,c+1} in [127:0]
//   ks_valid                 : keystream pair for the oldest word is present
//   o_valid/o_text/o_state/o_last : tag of the oldest word, zero when idle
//   err_proto                : sticky framing error
//   err_underflow            : sticky keystream-without-word error
module phase_scheduler
    import gcm_phase_pkg::*;
#(
    parameter int MAX_OUT = 16,
    parameter int GAP     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [TEXT_W-1:0] s_data,
    input  logic              s_sop,
    input  logic              s_eop,
    input  logic [IV_W-1:0]   s_iv,
    output logic              ctr_valid,
    input  logic              ctr_ready,
    output logic [BLK_W-1:0]  ctr_block,
    input  logic              ks_valid,
    output logic              o_valid,
    output logic [TEXT_W-1:0] o_text,
    output logic [PH_W-1:0]   o_state,
    output logic              o_last,
    output logic              err_proto,
    output logic              err_underflow
);

    localparam int CW       = $clog2(MAX_OUT) + 1;
    localparam int GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    state_t           state_q;
    logic [CTR_W-1:0] c_q;
    logic [IV_W-1:0]  iv_q;
    logic             ctrValid_q;
    logic [BLK_W-1:0] ctrBlock_q;
    logic             errProto_q;
    logic             errUnder_q;
    logic [GW-1:0]    gapCnt_q;

    logic             fifoEmpty;
    logic             fifoFull;
    logic [CW-1:0]    fifoCount;
    logic [TAG_W-1:0] fifoHead;
    tag_t             headTag;
    tag_t             pushTag;

    logic             inPacket;
    logic             accept;
    logic             issue;
    logic             pop;
    logic             drained;
    logic [PH_W-1:0]  pushPhase;
    logic [IV_W-1:0]  curIv;
    logic [CTR_W-1:0] curC;

    assign inPacket = (state_q == ST_SECOND) || (state_q == ST_INNER);

    // A word may enter only while a packet can start or continue, the
    // counter register is free (or draining this cycle), and there is room
    // to remember its tag.
    assign s_ready = (state_q != ST_DRAIN) && (state_q != ST_GAPWAIT)
                   && (!ctrValid_q || ctr_ready) && !fifoFull;
    assign accept  = s_valid && s_ready;

    // A non-sop word in IDLE is swallowed: accepted but never issued.
    assign issue     = accept && (s_sop || inPacket);
    assign pushPhase = s_sop ? PH_FIRST
                     : (state_q == ST_SECOND) ? PH_SECOND : PH_INNER;
    assign curIv     = s_sop ? s_iv : iv_q;
    assign curC      = s_sop ? CTR_W'(2) : c_q;

    assign pushTag.text  = s_data;
    assign pushTag.phase = pushPhase;
    assign pushTag.last  = s_eop;

    assign pop     = ks_valid && !fifoEmpty;
    assign drained = fifoEmpty || ((fifoCount == CW'(1)) && pop);

    phase_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUT)
    ) u_tagFifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (issue),
        .pushData_i (pushTag),
        .pop_i      (pop),
        .headData_o (fifoHead),
        .empty_o    (fifoEmpty),
        .full_o     (fifoFull),
        .count_o    (fifoCount)
    );

    assign headTag = tag_t'(fifoHead);

    // Output tag is forced to zero whenever no keystream is being matched.
    assign o_valid       = pop;
    assign o_text        = pop ? headTag.text  : '0;
    assign o_state       = pop ? headTag.phase : PH_NONE;
    assign o_last        = pop ? headTag.last  : 1'b0;
    assign ctr_valid     = ctrValid_q;
    assign ctr_block     = ctrBlock_q;
    assign err_proto     = errProto_q;
    assign err_underflow = errUnder_q;

    // Scheduler FSM with its registered outputs. A new packet always
    // restarts the counter at 2 because counter 1 is reserved for the tag
    // pre-block by the surrounding GCM core. After the last word the
    // scheduler waits for every keystream to come back, then holds off for
    // GAP cycles before the next packet may start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            c_q        <= CTR_W'(2);
            iv_q       <= '0;
            ctrValid_q <= 1'b0;
            ctrBlock_q <= '0;
            errProto_q <= 1'b0;
            errUnder_q <= 1'b0;
            gapCnt_q   <= '0;
        end else begin
            if (issue) begin
                ctrValid_q <= 1'b1;
                ctrBlock_q <= ctrPair(curIv, curC);
                c_q        <= curC + CTR_W'(2);
            end else if (ctr_ready) begin
                ctrValid_q <= 1'b0;
            end

            if (accept && s_sop) begin
                iv_q <= s_iv;
            end

            if (accept && ((s_sop && inPacket) || (!s_sop && state_q == ST_IDLE))) begin
                errProto_q <= 1'b1;
            end

            if (ks_valid && fifoEmpty) begin
                errUnder_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE, ST_SECOND, ST_INNER: begin
                    if (issue) begin
                        if (s_eop) begin
                            state_q <= ST_DRAIN;
                        end else if (s_sop) begin
                            state_q <= ST_SECOND;
                        end else begin
                            state_q <= ST_INNER;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        gapCnt_q <= '0;
                        state_q  <= (GAP == 0) ? ST_IDLE : ST_GAPWAIT;
                    end
                end
                ST_GAPWAIT: begin
                    if (gapCnt_q == GW'(GAP_LAST)) begin
                        gapCnt_q <= '0;
                        state_q  <= ST_IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q + GW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
